// File: rtl/mipi_csi_raw_depacker_if.sv
// Payload-in / pixel-beat-out bundle for mipi_csi_raw_depacker.
// The residue_err_o signal exists only when MIPI_CSI_DEPACK_RESIDUE_CHECK_EN is defined.
interface mipi_csi_raw_depacker_if #(
    parameter int PIXEL_WIDTH = 12
);
    logic                     data_valid_i;
    logic [31:0]              data_i;
    logic [2:0]               packet_type_i;
    logic                     output_valid_o;
    logic [4*PIXEL_WIDTH-1:0] pixels_o;
    logic                     line_end_o;
`ifdef MIPI_CSI_DEPACK_RESIDUE_CHECK_EN
    logic                     residue_err_o;

    modport master (
        output data_valid_i, data_i, packet_type_i,
        input  output_valid_o, pixels_o, line_end_o, residue_err_o
    );

    modport slave (
        input  data_valid_i, data_i, packet_type_i,
        output output_valid_o, pixels_o, line_end_o, residue_err_o
    );
`else
    modport master (
        output data_valid_i, data_i, packet_type_i,
        input  output_valid_o, pixels_o, line_end_o
    );

    modport slave (
        input  data_valid_i, data_i, packet_type_i,
        output output_valid_o, pixels_o, line_end_o
    );
`endif
endinterface

// File: rtl/mipi_csi_raw_depacker.sv
// Unpacks RAW10/RAW12 CSI-2 payload (4 bytes/clk) into 4-pixel beats, MSB-aligned.
// Optional feature macro: MIPI_CSI_DEPACK_RESIDUE_CHECK_EN (adds residue_err_o).
module mipi_csi_raw_depacker #(
    parameter int PIXEL_WIDTH = 12
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    mipi_csi_raw_depacker_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_RAW10,
        MODE_RAW12,
        MODE_DROP
    } mode_t;

    mode_t                    mode_q;
    mode_t                    mode_next;
    logic [63:0]              buf_q;
    logic [3:0]               count_q;
    logic                     valid_q;
    logic                     out_valid_q;
    logic [4*PIXEL_WIDTH-1:0] pixels_q;

    logic [95:0]              cat;
    logic [3:0]               cat_count;
    logic [3:0]               group_size;
    logic                     emit;
    logic [63:0]              rest;
    logic [4*PIXEL_WIDTH-1:0] beat;
    logic                     line_end;

    // Buffer bytes above count_q are kept zero, so new bytes can simply be OR-ed in behind them.
    always_comb begin
        mode_next = mode_q;
        if (mode_q == MODE_IDLE) begin
            case (bus.packet_type_i)
                3'h3:    mode_next = MODE_RAW10;
                3'h4:    mode_next = MODE_RAW12;
                default: mode_next = MODE_DROP;
            endcase
        end

        cat        = {32'd0, buf_q} | ({64'd0, bus.data_i} << {count_q, 3'b000});
        cat_count  = count_q + 4'd4;
        group_size = (mode_next == MODE_RAW12) ? 4'd6 : 4'd5;
        emit       = bus.data_valid_i
                     && ((mode_next == MODE_RAW10) || (mode_next == MODE_RAW12))
                     && (cat_count >= group_size);
        rest       = 64'(cat >> {group_size, 3'b000});

        beat = '0;
        for (int n = 0; n < 4; n++) begin
            if (mode_next == MODE_RAW12) begin
                beat[n*PIXEL_WIDTH + PIXEL_WIDTH - 12 +: 12] =
                    {cat[8*((n < 2) ? n : n + 1) +: 8], cat[8*((n < 2) ? 2 : 5) + 4*(n % 2) +: 4]};
            end else begin
                beat[n*PIXEL_WIDTH + PIXEL_WIDTH - 10 +: 10] = {cat[8*n +: 8], cat[32 + 2*n +: 2]};
            end
        end
    end

    // Any invalid cycle ends the packet: residue is discarded and the next type gets re-latched.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mode_q      <= MODE_IDLE;
            buf_q       <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            out_valid_q <= 1'b0;
            pixels_q    <= '0;
        end else begin
            valid_q     <= bus.data_valid_i;
            out_valid_q <= emit;
            if (emit) begin
                pixels_q <= beat;
            end

            if (!bus.data_valid_i) begin
                mode_q  <= MODE_IDLE;
                buf_q   <= '0;
                count_q <= '0;
            end else if (mode_next == MODE_DROP) begin
                mode_q  <= mode_next;
                buf_q   <= '0;
                count_q <= '0;
            end else if (emit) begin
                mode_q  <= mode_next;
                buf_q   <= rest;
                count_q <= cat_count - group_size;
            end else begin
                mode_q  <= mode_next;
                buf_q   <= cat[63:0];
                count_q <= cat_count;
            end
        end
    end

    assign line_end           = valid_q && !bus.data_valid_i;
    assign bus.line_end_o     = line_end;
    assign bus.output_valid_o = out_valid_q;
    assign bus.pixels_o       = pixels_q;

`ifdef MIPI_CSI_DEPACK_RESIDUE_CHECK_EN
    assign bus.residue_err_o = line_end && ((count_q != 4'd0) || (mode_q == MODE_DROP));
`endif

endmodule
